// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
// Round-robin pop scheduler for eight show-ahead FIFOs sharing one 8:1 read mux.
// Each cycle one requesting source is popped. The muxed word is captured, tagged
// with its source index, into a one-entry valid/ready output register.
module fifo_drain_arbiter #(
   parameter int bw   = 4,
   parameter int simd = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic [7:0]           req,
   output logic [7:0]           rd,
   output logic [2:0]           sel,
   input  logic [simd*bw-1:0]   mux_out,
   output logic [simd*bw-1:0]   out_data,
   output logic [2:0]           out_src,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int W = simd * bw;

   logic [2:0]   last_gnt_q, last_gnt_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic [2:0]   out_src_q, out_src_d;

   // Requests rotated so that bit k is the source k+1 places after the last grant.
   logic [7:0]   req_rot;
   logic [2:0]   rot_offset;
   logic [2:0]   gnt_idx;
   logic         slot_free;
   logic         grant;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign req_rot[gi] = req[3'(last_gnt_q + 3'(gi + 1))];
      end
   endgenerate

   // Priority-encode the rotated request vector: lowest set bit wins.
   always_comb begin
      logic found;
      found      = 1'b0;
      rot_offset = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (!found && req_rot[k]) begin
            found      = 1'b1;
            rot_offset = 3'(k);
         end
      end
   end

   // Grant decision, pop strobe and mux select; reset_n gates rd so that an
   // asserted reset silences the FIFOs without waiting for a clock edge.
   always_comb begin
      slot_free = !out_valid_q || out_ready;
      grant     = en && slot_free && (req != 8'd0) && reset_n;
      gnt_idx   = last_gnt_q + rot_offset + 3'd1;
      rd        = 8'd0;
      sel       = last_gnt_q;
      if (grant) begin
         rd  = 8'd1 << gnt_idx;
         sel = gnt_idx;
      end
   end

   // Next state of the output register and round-robin pointer.
   always_comb begin
      last_gnt_d  = last_gnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (grant) begin
         // An accept in the same cycle is implied by slot_free: word replaced, no bubble.
         last_gnt_d  = gnt_idx;
         out_valid_d = 1'b1;
         out_data_d  = mux_out;
         out_src_d   = gnt_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; last_gnt resets to 7 so source 0 is scanned first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_q  <= 3'd7;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 3'd0;
      end else begin
         last_gnt_q  <= last_gnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Testbench for fifo_drain_arbiter: table of per-cycle vectors with expected
// rd/sel/out_valid, plus a scoreboard queue checking out_data/out_src words.
module tb_fifo_drain_arbiter;

   localparam int BW   = 4;
   localparam int SIMD = 2;
   localparam int W    = BW * SIMD;

   logic         clk;
   logic         reset_n;
   logic         en;
   logic [7:0]   req;
   logic [7:0]   rd;
   logic [2:0]   sel;
   logic [W-1:0] mux_out;
   logic [W-1:0] out_data;
   logic [2:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   fifo_drain_arbiter #(.bw(BW), .simd(SIMD)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .req       (req),
      .rd        (rd),
      .sel       (sel),
      .mux_out   (mux_out),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic       ready;
      logic [7:0] exp_rd;
      logic [2:0] exp_sel;
      logic       exp_valid;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      logic [2:0]   src;
   } word_t;

   vec_t  vecs[$];
   word_t sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic e, input logic [7:0] r, input logic rdy,
                               input logic [7:0] xrd, input logic [2:0] xsel, input logic xv);
      vec_t v;
      v.en = e; v.req = r; v.ready = rdy;
      v.exp_rd = xrd; v.exp_sel = xsel; v.exp_valid = xv;
      vecs.push_back(v);
   endfunction

   // Compare the current output word against the scoreboard head.
   task automatic check_word(input string tag);
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_sb_empty: got out_src=%0d, expected a queued word", tag, out_src);
      end else begin
         check({tag, "_data"}, 32'(out_data), 32'(sb[0].data));
         check({tag, "_src"},  32'(out_src),  32'(sb[0].src));
      end
   endtask

   // Apply one vector: drive after the edge, compare just before the next edge.
   task automatic run_row(input vec_t v, input int idx);
      word_t w;
      @(posedge clk);
      #1;
      en        = v.en;
      req       = v.req;
      out_ready = v.ready;
      mux_out   = W'($urandom);
      #3;
      check($sformatf("row%0d_rd", idx),    32'(rd),        32'(v.exp_rd));
      check($sformatf("row%0d_sel", idx),   32'(sel),       32'(v.exp_sel));
      check($sformatf("row%0d_valid", idx), 32'(out_valid), 32'(v.exp_valid));
      if (v.exp_valid) begin
         check_word($sformatf("row%0d", idx));
         if (v.ready && sb.size() != 0) void'(sb.pop_front());
      end
      if (v.exp_rd != 8'd0) begin
         w.data = mux_out;
         w.src  = v.exp_sel;
         sb.push_back(w);
      end
      $display("row %0d: en=%0b req=%02h ready=%0b -> rd=%02h sel=%0d valid=%0b src=%0d data=%0h",
               idx, v.en, v.req, v.ready, rd, sel, out_valid, out_src, out_data);
   endtask

   initial begin
      word_t w;
      logic [2:0] s;

      // Single source: lone requester granted every cycle.
      add(1, 8'h01, 1, 8'h01, 3'd0, 0);
      for (int i = 0; i < 3; i++) add(1, 8'h01, 1, 8'h01, 3'd0, 1);
      // Full rotation starting after last grant 0.
      for (int i = 0; i < 10; i++) begin
         s = 3'(i + 1);
         add(1, 8'hFF, 1, 8'd1 << s, s, 1);
      end
      // Sparse wrap-around, last grant 2.
      add(1, 8'h84, 1, 8'h80, 3'd7, 1);
      add(1, 8'h84, 1, 8'h04, 3'd2, 1);
      add(1, 8'h84, 1, 8'h80, 3'd7, 1);
      add(1, 8'h84, 1, 8'h04, 3'd2, 1);
      // Backpressure: grant 3, stall three cycles, then accept with grant 4.
      add(1, 8'hFF, 1, 8'h08, 3'd3, 1);
      for (int i = 0; i < 3; i++) add(1, 8'hFF, 0, 8'h00, 3'd3, 1);
      add(1, 8'hFF, 1, 8'h10, 3'd4, 1);
      // en low drains; empty req gives no grant; resume from last_gnt+1.
      add(0, 8'hFF, 1, 8'h00, 3'd4, 1);
      add(0, 8'hFF, 1, 8'h00, 3'd4, 0);
      add(1, 8'h00, 1, 8'h00, 3'd4, 0);
      add(1, 8'hFF, 1, 8'h20, 3'd5, 0);
      add(0, 8'hFF, 0, 8'h00, 3'd5, 1);
      add(0, 8'hFF, 1, 8'h00, 3'd5, 1);
      add(0, 8'hFF, 1, 8'h00, 3'd5, 0);
      // Empty slot grants even with out_ready low; then stalls; then accept+grant.
      add(1, 8'h40, 0, 8'h40, 3'd6, 0);
      add(1, 8'h40, 0, 8'h00, 3'd6, 1);
      add(1, 8'h40, 1, 8'h40, 3'd6, 1);
      add(0, 8'h00, 1, 8'h00, 3'd6, 1);

      // Reset state, with requests present to show rd is gated.
      reset_n = 1'b0; en = 1'b1; req = 8'hFF; out_ready = 1'b1; mux_out = '0;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data",  32'(out_data),  32'd0);
      check("rst_src",   32'(out_src),   32'd0);
      check("rst_rd",    32'(rd),        32'd0);
      check("rst_sel",   32'(sel),       32'd7);
      en = 1'b0; req = 8'h00;
      #1 reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

      // Reset mid-stream: capture a word from source 7, then reset between edges.
      begin
         vec_t v;
         v.en = 1; v.req = 8'hFF; v.ready = 0; v.exp_rd = 8'h80; v.exp_sel = 3'd7; v.exp_valid = 0;
         run_row(v, vecs.size());
      end
      @(posedge clk);
      #2;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check_word("pre_rst");
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_rd",    32'(rd),        32'd0);
      check("mid_rst_sel",   32'(sel),       32'd7);
      sb.delete();
      req = 8'h30; en = 1'b1; out_ready = 1'b1; mux_out = W'($urandom);
      reset_n = 1'b1;
      #1;
      check("post_rst_rd",  32'(rd),  32'h10);
      check("post_rst_sel", 32'(sel), 32'd4);
      w.data = mux_out; w.src = 3'd4;
      sb.push_back(w);
      @(posedge clk);
      #1;
      en = 1'b0;
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check_word("post_rst");
      $display("reset sequence: out_src=%0d out_data=%0h", out_src, out_data);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
